// File: rtl/pwm_ctrl_pkg.sv
// Shared types and constants for the PWM duty-sequencing blocks.
package pwm_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } ramp_state_e;

    localparam int DUTY_W_DEF = 8;
    localparam int STEP_W     = 4;

endpackage

// File: rtl/pwm_ramp_ctrl_if.sv
// Control/status bundle between the SPI register file, the ramp sequencer and the PWM core.
interface pwm_ramp_ctrl_if
    import pwm_ctrl_pkg::*;
#(
    parameter int DUTY_W = DUTY_W_DEF,
    parameter int RATE_W = 8
);

    logic [DUTY_W-1:0] target_duty;
    logic              ramp_en;
    logic [RATE_W-1:0] ramp_rate;
    logic [STEP_W-1:0] ramp_step;
    logic [DUTY_W-1:0] duty_out;
    logic              busy;
    logic              done;

    modport master (
        output target_duty, ramp_en, ramp_rate, ramp_step,
        input  duty_out, busy, done
    );

    modport slave (
        input  target_duty, ramp_en, ramp_rate, ramp_step,
        output duty_out, busy, done
    );

endinterface

// File: rtl/pwm_ramp_ctrl_tick_divider.sv
// Free-running clock prescaler: one-cycle tick every PREDIV enabled cycles, sync clear.
module tick_divider #(
    parameter int PREDIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (PREDIV > 1) ? $clog2(PREDIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PREDIV - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Duty-cycle sequencer: bypasses or slews the SPI target duty toward the PWM core.
module pwm_ramp_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int DUTY_W = DUTY_W_DEF,
    parameter int RATE_W = 8,
    parameter int PREDIV = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pwm_ramp_ctrl_if.slave        bus
);

    ramp_state_e       state_q, state_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [RATE_W-1:0] rate_q, rate_d;
    logic              done_q, done_d;
    logic              tick;
    logic              div_clr;

    // Widened by one bit so the add/subtract can be clamped instead of wrapping.
    function automatic logic [DUTY_W-1:0] step_toward(
        input logic [DUTY_W-1:0] cur,
        input logic [DUTY_W-1:0] tgt,
        input logic [STEP_W-1:0] step
    );
        logic [DUTY_W:0] s;
        logic [DUTY_W:0] cur_x;
        logic [DUTY_W:0] tgt_x;
        logic [DUTY_W:0] res;
        s     = {{(DUTY_W + 1 - STEP_W){1'b0}}, (step == '0) ? STEP_W'(1) : step};
        cur_x = {1'b0, cur};
        tgt_x = {1'b0, tgt};
        if (tgt_x > cur_x) begin
            res = cur_x + s;
            if (res > tgt_x) res = tgt_x;
        end else begin
            if (cur_x < tgt_x + s) res = tgt_x;
            else                   res = cur_x - s;
        end
        return res[DUTY_W-1:0];
    endfunction

    tick_divider #(
        .PREDIV (PREDIV)
    ) u_tick_divider (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (div_clr),
        .en    (state_q == RAMP),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        rate_d  = rate_q;
        done_d  = 1'b0;
        div_clr = 1'b0;
        case (state_q)
            IDLE: begin
                div_clr = 1'b1;
                rate_d  = '0;
                if (!bus.ramp_en) begin
                    duty_d = bus.target_duty;
                end else if (bus.target_duty != duty_q) begin
                    state_d = RAMP;
                end
            end
            RAMP: begin
                if (!bus.ramp_en) begin
                    duty_d  = bus.target_duty;
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (bus.target_duty == duty_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (tick) begin
                    if (rate_q == bus.ramp_rate) begin
                        // Direction comes from the live target, so a moved target reverses cleanly.
                        rate_d = '0;
                        duty_d = step_toward(duty_q, bus.target_duty, bus.ramp_step);
                        if (duty_d == bus.target_duty) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        rate_d = rate_q + RATE_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            duty_q  <= '0;
            rate_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            rate_q  <= rate_d;
            done_q  <= done_d;
        end
    end

    assign bus.duty_out = duty_q;
    assign bus.busy     = (state_q == RAMP);
    assign bus.done     = done_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: per-cycle expectations queued, then popped and checked.
module tb_pwm_ramp_ctrl;

    typedef struct {
        logic [7:0] duty;
        logic       busy;
        logic       done;
        string      tag;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    exp_t sb[$];
    exp_t sb2[$];

    pwm_ramp_ctrl_if #(.DUTY_W(8), .RATE_W(8)) bus1 ();
    pwm_ramp_ctrl_if #(.DUTY_W(8), .RATE_W(8)) bus2 ();

    pwm_ramp_ctrl #(.DUTY_W(8), .RATE_W(8), .PREDIV(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    pwm_ramp_ctrl #(.DUTY_W(8), .RATE_W(8), .PREDIV(3)) dut_div3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, observed running required finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic en, input logic [7:0] rate, input logic [3:0] step,
                          input logic [7:0] tgt);
        bus1.ramp_en     = en;
        bus1.ramp_rate   = rate;
        bus1.ramp_step   = step;
        bus1.target_duty = tgt;
        bus2.ramp_en     = en;
        bus2.ramp_rate   = rate;
        bus2.ramp_step   = step;
        bus2.target_duty = tgt;
    endtask

    task automatic push(input logic [7:0] d, input logic b, input logic dn, input string tag);
        exp_t e;
        e.duty = d; e.busy = b; e.done = dn; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic push2(input logic [7:0] d, input logic b, input logic dn, input string tag);
        exp_t e;
        e.duty = d; e.busy = b; e.done = dn; e.tag = tag;
        sb2.push_back(e);
    endtask

    task automatic run_cycles(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $error("FAIL sb_empty: observed 0 entries required 1");
            end else begin
                e = sb.pop_front();
                chk({e.tag, ".duty"}, 32'(bus1.duty_out), 32'(e.duty));
                chk({e.tag, ".busy"}, 32'(bus1.busy), 32'(e.busy));
                chk({e.tag, ".done"}, 32'(bus1.done), 32'(e.done));
            end
            if (sb2.size() != 0) begin
                e = sb2.pop_front();
                chk({e.tag, ".div3_duty"}, 32'(bus2.duty_out), 32'(e.duty));
                chk({e.tag, ".div3_busy"}, 32'(bus2.busy), 32'(e.busy));
                chk({e.tag, ".div3_done"}, 32'(bus2.done), 32'(e.done));
            end
        end
    endtask

    initial begin
        logic [7:0] v;
        clk     = 1'b0;
        rst_n   = 1'b0;
        n_tests = 0;
        n_fail  = 0;
        set_in(1'b0, 8'd0, 4'd0, 8'h00);

        #12;
        chk("reset.duty", 32'(bus1.duty_out), 32'h0);
        chk("reset.busy", 32'(bus1.busy), 32'h0);
        chk("reset.done", 32'(bus1.done), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Prescaler: PREDIV=1 and PREDIV=3 instances ramp 0 -> 2 with step 1, rate 0.
        set_in(1'b1, 8'd0, 4'd1, 8'h02);
        push(8'h00, 1, 0, "pre1_e1");
        push(8'h01, 1, 0, "pre1_e2");
        push(8'h02, 0, 1, "pre1_e3");
        for (int k = 4; k <= 8; k++) push(8'h02, 0, 0, "pre1_idle");
        for (int k = 1; k <= 3; k++) push2(8'h00, 1, 0, "pre3_wait1");
        for (int k = 4; k <= 6; k++) push2(8'h01, 1, 0, "pre3_step1");
        push2(8'h02, 0, 1, "pre3_done");
        push2(8'h02, 0, 0, "pre3_idle");
        run_cycles(8);

        // Bypass.
        set_in(1'b0, 8'd0, 4'd0, 8'h80);
        push(8'h80, 0, 0, "bypass_e1");
        push(8'h80, 0, 0, "bypass_e2");
        run_cycles(2);

        // Basic ramp 0 -> 0x20, rate 3, step 8.
        set_in(1'b0, 8'd0, 4'd0, 8'h00);
        push(8'h00, 0, 0, "basic_prep");
        run_cycles(1);
        set_in(1'b1, 8'd3, 4'd8, 8'h20);
        push(8'h00, 1, 0, "basic_entry");
        for (int k = 2; k <= 16; k++) push(8'(8 * ((k - 1) / 4)), 1, 0, "basic_ramp");
        push(8'h20, 0, 1, "basic_done");
        push(8'h20, 0, 0, "basic_after");
        run_cycles(18);

        // Saturation up: 0 -> 0x25 with step 0xF.
        set_in(1'b0, 8'd0, 4'd0, 8'h00);
        push(8'h00, 0, 0, "satup_prep");
        run_cycles(1);
        set_in(1'b1, 8'd0, 4'hF, 8'h25);
        push(8'h00, 1, 0, "satup_entry");
        push(8'h0F, 1, 0, "satup_s1");
        push(8'h1E, 1, 0, "satup_s2");
        push(8'h25, 0, 1, "satup_clamp");
        push(8'h25, 0, 0, "satup_after");
        run_cycles(5);

        // Saturation down: 0xF0 -> 0x05 with step 0xF.
        set_in(1'b0, 8'd0, 4'd0, 8'hF0);
        push(8'hF0, 0, 0, "satdn_prep");
        run_cycles(1);
        set_in(1'b1, 8'd0, 4'hF, 8'h05);
        push(8'hF0, 1, 0, "satdn_entry");
        v = 8'hF0;
        for (int k = 0; k < 15; k++) begin
            v = v - 8'd15;
            push(v, 1, 0, "satdn_step");
        end
        push(8'h05, 0, 1, "satdn_clamp");
        push(8'h05, 0, 0, "satdn_after");
        run_cycles(18);

        // Top of range: 0xF8 + 0xF must clamp to 0xFF, not wrap.
        set_in(1'b0, 8'd0, 4'd0, 8'hF8);
        push(8'hF8, 0, 0, "sattop_prep");
        run_cycles(1);
        set_in(1'b1, 8'd0, 4'hF, 8'hFF);
        push(8'hF8, 1, 0, "sattop_entry");
        push(8'hFF, 0, 1, "sattop_clamp");
        run_cycles(2);

        // Mid-ramp reversal at 0x20 toward 0x10.
        set_in(1'b0, 8'd0, 4'd0, 8'h00);
        push(8'h00, 0, 0, "rev_prep");
        run_cycles(1);
        set_in(1'b1, 8'd0, 4'd4, 8'h80);
        push(8'h00, 1, 0, "rev_entry");
        for (int k = 1; k <= 8; k++) push(8'(4 * k), 1, 0, "rev_up");
        run_cycles(9);
        set_in(1'b1, 8'd0, 4'd4, 8'h10);
        push(8'h1C, 1, 0, "rev_dn1");
        push(8'h18, 1, 0, "rev_dn2");
        push(8'h14, 1, 0, "rev_dn3");
        push(8'h10, 0, 1, "rev_done");
        push(8'h10, 0, 0, "rev_after");
        run_cycles(5);

        // ramp_step = 0 behaves as 1.
        set_in(1'b0, 8'd0, 4'd0, 8'h00);
        push(8'h00, 0, 0, "step0_prep");
        run_cycles(1);
        set_in(1'b1, 8'd0, 4'd0, 8'h03);
        push(8'h00, 1, 0, "step0_entry");
        push(8'h01, 1, 0, "step0_s1");
        push(8'h02, 1, 0, "step0_s2");
        push(8'h03, 0, 1, "step0_done");
        push(8'h03, 0, 0, "step0_after");
        run_cycles(5);

        // ramp_en dropped mid-ramp jumps to target with done.
        set_in(1'b0, 8'd0, 4'd0, 8'h00);
        push(8'h00, 0, 0, "abort_prep");
        run_cycles(1);
        set_in(1'b1, 8'd0, 4'd8, 8'h80);
        push(8'h00, 1, 0, "abort_entry");
        push(8'h08, 1, 0, "abort_s1");
        push(8'h10, 1, 0, "abort_s2");
        push(8'h18, 1, 0, "abort_s3");
        run_cycles(4);
        set_in(1'b0, 8'd0, 4'd8, 8'h80);
        push(8'h80, 0, 1, "abort_jump");
        push(8'h80, 0, 0, "abort_after");
        run_cycles(2);

        // Target moved onto current duty between steps.
        set_in(1'b1, 8'd3, 4'd1, 8'h00);
        for (int k = 1; k <= 4; k++) push(8'h80, 1, 0, "meet_wait");
        push(8'h7F, 1, 0, "meet_s1");
        run_cycles(5);
        set_in(1'b1, 8'd3, 4'd1, 8'h7F);
        push(8'h7F, 0, 1, "meet_done");
        push(8'h7F, 0, 0, "meet_after");
        run_cycles(2);

        // Asynchronous reset in the middle of a ramp.
        set_in(1'b1, 8'd0, 4'd1, 8'h00);
        push(8'h7F, 1, 0, "rst_entry");
        push(8'h7E, 1, 0, "rst_s1");
        push(8'h7D, 1, 0, "rst_s2");
        run_cycles(3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst.duty", 32'(bus1.duty_out), 32'h0);
        chk("async_rst.busy", 32'(bus1.busy), 32'h0);
        chk("async_rst.done", 32'(bus1.done), 32'h0);
        #2;
        rst_n = 1'b1;
        push(8'h00, 0, 0, "rst_after");
        run_cycles(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
